// File: rtl/crtc_init_sequencer.sv
// Programs CRTC registers R0..NUM_REGS-1 from a preset table over the shared CPU bus.
// Optional CRTC_INIT_ON_RESET_EN: auto-start with mode 0 on the first clock after reset.
module crtc_init_sequencer #(
  parameter int unsigned NUM_REGS = 14
) (
  input  logic       sys_clock_i,
  input  logic       reset_i,
  input  logic       clk_en_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       cpu_cs_i,
  input  logic       cpu_rs_i,
  input  logic       cpu_we_i,
  input  logic [7:0] cpu_data_i,
  output logic       crtc_cs_o,
  output logic       crtc_rs_o,
  output logic       crtc_we_o,
  output logic [7:0] crtc_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       preempt_o
);

  typedef enum logic [1:0] {IDLE, SELECT, WRITE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  localparam logic [7:0] PRESET0 [16] = '{
    8'd49, 8'd40, 8'd41, 8'h0F, 8'd40, 8'd5, 8'd25, 8'd33,
    8'd0,  8'd7,  8'd0,  8'd0,  8'd0,  8'd0, 8'd0,  8'd0
  };
  localparam logic [7:0] PRESET1 [16] = '{
    8'd5, 8'd3, 8'd4, 8'h11, 8'd4, 8'd2, 8'd2, 8'd3,
    8'd0, 8'd2, 8'd0, 8'd0,  8'd0, 8'd0, 8'd0, 8'd0
  };

  state_t     state;
  logic [3:0] idx;
  logic       mode_q;
  logic       auto_start;
  logic [7:0] preset_data;

`ifdef CRTC_INIT_ON_RESET_EN
  logic init_pend;

  always_ff @(posedge sys_clock_i or posedge reset_i) begin
    if (reset_i) init_pend <= 1'b1;
    else         init_pend <= 1'b0;
  end

  assign auto_start = init_pend;
`else
  assign auto_start = 1'b0;
`endif

  assign preset_data = mode_q ? PRESET1[idx] : PRESET0[idx];

  always_ff @(posedge sys_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      idx       <= '0;
      mode_q    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      preempt_o <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      preempt_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i || auto_start) begin
            state  <= SELECT;
            idx    <= '0;
            mode_q <= auto_start ? 1'b0 : mode_i;
            busy_o <= 1'b1;
          end
        end
        SELECT: begin
          if (clk_en_i) begin
            if (cpu_cs_i) preempt_o <= 1'b1;
            else          state     <= WRITE;
          end
        end
        WRITE: begin
          if (clk_en_i) begin
            // CPU may have moved the CRTC address register, so re-select the same idx
            if (cpu_cs_i) begin
              preempt_o <= 1'b1;
              state     <= SELECT;
            end else if (idx == LAST_IDX) begin
              state  <= IDLE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state <= SELECT;
              idx   <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    crtc_cs_o   = 1'b0;
    crtc_rs_o   = 1'b0;
    crtc_we_o   = 1'b0;
    crtc_data_o = '0;
    if (cpu_cs_i) begin
      crtc_cs_o   = 1'b1;
      crtc_rs_o   = cpu_rs_i;
      crtc_we_o   = cpu_we_i;
      crtc_data_o = cpu_data_i;
    end else if (state == SELECT) begin
      crtc_cs_o   = 1'b1;
      crtc_we_o   = 1'b1;
      crtc_data_o = {4'b0000, idx};
    end else if (state == WRITE) begin
      crtc_cs_o   = 1'b1;
      crtc_rs_o   = 1'b1;
      crtc_we_o   = 1'b1;
      crtc_data_o = preset_data;
    end
  end

endmodule

// File: tb/tb_crtc_init_sequencer.sv
// Directed bench for crtc_init_sequencer with a small CRTC register-file model.
`timescale 1ns/1ps
module tb_crtc_init_sequencer;

  logic       sys_clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       clk_en_i = 1'b0;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic       cpu_cs_i = 1'b0;
  logic       cpu_rs_i = 1'b0;
  logic       cpu_we_i = 1'b0;
  logic [7:0] cpu_data_i = '0;
  logic       crtc_cs_o, crtc_rs_o, crtc_we_o;
  logic [7:0] crtc_data_o;
  logic       busy_o, done_o, preempt_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] p0 [14] = '{8'd49, 8'd40, 8'd41, 8'h0F, 8'd40, 8'd5, 8'd25, 8'd33, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] p1 [14] = '{8'd5, 8'd3, 8'd4, 8'h11, 8'd4, 8'd2, 8'd2, 8'd3, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0};

  logic [3:0] m_addr = '0;
  logic [7:0] m_regs [16];

  typedef struct {
    logic       en;
    logic       exp_cs;
    logic       exp_rs;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;
  vec_t tbl [$];

  crtc_init_sequencer #(.NUM_REGS(14)) dut (
    .sys_clock_i(sys_clock_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .start_i(start_i), .mode_i(mode_i),
    .cpu_cs_i(cpu_cs_i), .cpu_rs_i(cpu_rs_i), .cpu_we_i(cpu_we_i), .cpu_data_i(cpu_data_i),
    .crtc_cs_o(crtc_cs_o), .crtc_rs_o(crtc_rs_o), .crtc_we_o(crtc_we_o), .crtc_data_o(crtc_data_o),
    .busy_o(busy_o), .done_o(done_o), .preempt_o(preempt_o)
  );

  always #5 sys_clock_i = ~sys_clock_i;

  // CRTC register file as seen from its bus: address write (rs=0), data write (rs=1)
  always @(posedge sys_clock_i) begin
    if (clk_en_i && crtc_cs_o && crtc_we_o) begin
      if (!crtc_rs_o) m_addr <= crtc_data_o[3:0];
      else            m_regs[m_addr] <= crtc_data_o;
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] pre(input int m, input int i);
    return (m != 0) ? p1[i] : p0[i];
  endfunction

  task automatic step(input logic en, input logic ccs, input logic crs, input logic cwe,
                      input logic [7:0] cd, input logic st,
                      input logic ecs, input logic ers, input logic ewe, input logic [7:0] ed,
                      input logic eb, input logic edn, input logic ep, input string nm);
    @(negedge sys_clock_i);
    clk_en_i = en; cpu_cs_i = ccs; cpu_rs_i = crs; cpu_we_i = cwe; cpu_data_i = cd; start_i = st;
    #1;
    chk({nm, " cs"}, 8'(crtc_cs_o), 8'(ecs));
    chk({nm, " rs"}, 8'(crtc_rs_o), 8'(ers));
    chk({nm, " we"}, 8'(crtc_we_o), 8'(ewe));
    chk({nm, " data"}, crtc_data_o, ed);
    @(posedge sys_clock_i);
    #1;
    chk({nm, " busy"}, 8'(busy_o), 8'(eb));
    chk({nm, " done"}, 8'(done_o), 8'(edn));
    chk({nm, " preempt"}, 8'(preempt_o), 8'(ep));
    clk_en_i = 1'b0; cpu_cs_i = 1'b0; cpu_rs_i = 1'b0; cpu_we_i = 1'b0; cpu_data_i = '0; start_i = 1'b0;
  endtask

  // Uninterrupted slot k: even = select R(k/2), odd = write preset
  task automatic norm(input int m, input int k, input logic st);
    logic [7:0] ed;
    ed = (k % 2 == 0) ? 8'(k / 2) : pre(m, k / 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, st, 1'b1, 1'(k % 2), 1'b1, ed,
         (k != 27), (k == 27), 1'b0, $sformatf("m%0d slot%0d", m, k));
  endtask

  task automatic start_seq(input int m, input logic en);
    @(negedge sys_clock_i);
    start_i = 1'b1; mode_i = 1'(m); clk_en_i = en;
    @(posedge sys_clock_i);
    #1;
    start_i = 1'b0; clk_en_i = 1'b0;
    chk("start busy", 8'(busy_o), 8'd1);
    chk("start cs", 8'(crtc_cs_o), 8'd1);
    chk("start rs", 8'(crtc_rs_o), 8'd0);
    chk("start data", crtc_data_o, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = '0;

    // Reset state, including CPU pass-through while in reset
    repeat (2) @(posedge sys_clock_i);
    #1;
    chk("rst busy", 8'(busy_o), 8'd0);
    chk("rst done", 8'(done_o), 8'd0);
    chk("rst preempt", 8'(preempt_o), 8'd0);
    chk("rst cs", 8'(crtc_cs_o), 8'd0);
    chk("rst data", crtc_data_o, 8'd0);
    cpu_cs_i = 1'b1; cpu_rs_i = 1'b1; cpu_data_i = 8'hA5;
    #1;
    chk("rst passthru data", crtc_data_o, 8'hA5);
    chk("rst passthru rs", 8'(crtc_rs_o), 8'd1);
    cpu_cs_i = 1'b0; cpu_rs_i = 1'b0; cpu_data_i = '0;
    @(negedge sys_clock_i);
    reset_i = 1'b0;
    @(posedge sys_clock_i);
    #1;
`ifdef CRTC_INIT_ON_RESET_EN
    chk("auto busy", 8'(busy_o), 8'd1);
    for (int k = 0; k < 28; k++) norm(0, k, 1'b0);
    chk("auto R0", m_regs[0], 8'd49);
    chk("auto R7", m_regs[7], 8'd33);
`else
    chk("no auto busy", 8'(busy_o), 8'd0);
    chk("no auto cs", 8'(crtc_cs_o), 8'd0);
`endif

    // Idle pass-through: select R1, write 80
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, "idle sel");
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'd80, 1'b0, 1'b1, 1'b1, 1'b1, 8'd80, 1'b0, 1'b0, 1'b0, "idle wr");
    chk("idle R1", m_regs[1], 8'd80);

    // Mode 1 full sequence from a vector table, with a stalled cycle mid-way
    for (int k = 0; k < 28; k++) begin
      tbl.push_back('{1'b1, 1'b1, 1'(k % 2), (k % 2 == 0) ? 8'(k / 2) : p1[k / 2], (k != 27), (k == 27)});
      if (k == 5) tbl.push_back('{1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0});
    end
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
    start_seq(1, 1'b0);
    foreach (tbl[i])
      step(tbl[i].en, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, tbl[i].exp_cs, tbl[i].exp_rs, tbl[i].exp_cs,
           tbl[i].exp_data, tbl[i].exp_busy, tbl[i].exp_done, 1'b0, $sformatf("tbl%0d", i));
    chk("m1 R0", m_regs[0], 8'd5);
    chk("m1 R3", m_regs[3], 8'h11);
    chk("m1 R9", m_regs[9], 8'd2);

    // Preempt in WRITE of R3: CPU selects R12, sequencer re-selects R3 (30 strobes)
    m_regs[3] = '0;
    start_seq(1, 1'b0);
    for (int k = 0; k < 7; k++) norm(1, k, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b1, "pre wr");
    for (int k = 6; k < 28; k++) norm(1, k, 1'b0);
    chk("pre wr R3", m_regs[3], 8'h11);

    // Preempt in SELECT of R7: CPU write on that strobe (29 strobes)
    m_regs[7] = '0;
    start_seq(1, 1'b0);
    for (int k = 0; k < 14; k++) norm(1, k, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, "pre sel");
    for (int k = 14; k < 28; k++) norm(1, k, 1'b0);
    chk("pre sel R7", m_regs[7], 8'd3);

    // Start while busy is ignored; strobe during the acceptance cycle is not counted
    start_seq(1, 1'b1);
    for (int k = 0; k < 28; k++) norm(1, k, (k == 9));

    // Async reset mid-sequence, then restart in mode 0 from idx 0
    start_seq(1, 1'b0);
    for (int k = 0; k < 11; k++) norm(1, k, 1'b0);
    @(negedge sys_clock_i);
    reset_i = 1'b1;
    #1;
    chk("arst busy", 8'(busy_o), 8'd0);
    chk("arst cs", 8'(crtc_cs_o), 8'd0);
    @(posedge sys_clock_i);
    @(negedge sys_clock_i);
    reset_i = 1'b0;
    start_seq(0, 1'b0);
    for (int k = 0; k < 28; k++) norm(0, k, 1'b0);
    chk("m0 R0", m_regs[0], 8'd49);
    chk("m0 R3", m_regs[3], 8'h0F);
    chk("m0 R9", m_regs[9], 8'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
